peripheral_mult_gen: RTL and testbench

Parametrised, memory-mapped sequential multiplier peripheral on the processor bus, successor to the fixed 16-bit multiplier peripheral. It keeps that block's register offsets and bus handshake (`cs`/`rd`/`wr`/`addr`). It adds:
- configurable operand width;
- a signed (two's-complement) mode;
- a busy flag, read-to-clear done and a level interrupt.

The result is computed by a radix-2 shift-add engine in WIDTH cycles.

---
 rtl/peripheral_mult_pkg.sv | 32 +++
 rtl/mult_shift_add_core.sv | 100 ++++++++++
 rtl/peripheral_mult_gen.sv | 132 +++++++++++++
 tb/tb_peripheral_mult_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/peripheral_mult_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_mult_pkg
// Shared definitions for the memory-mapped sequential multiplier peripheral:
// register byte offsets, CTRL/STATUS bit positions and the engine FSM states.
// No ports; imported by peripheral_mult_gen and mult_shift_add_core.
// -----------------------------------------------------------------------------
package peripheral_mult_pkg;

    // Register byte offsets (bus address width is applied by the top level)
    localparam int unsigned OFF_A      = 'h04;
    localparam int unsigned OFF_B      = 'h08;
    localparam int unsigned OFF_CTRL   = 'h0C;
    localparam int unsigned OFF_STATUS = 'h10;
    localparam int unsigned OFF_RESULT = 'h14;

    // CTRL bits
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_SIGNED_BIT = 1;
    localparam int CTRL_IE_BIT     = 2;

    // STATUS bits
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_shift_add_core.sv
// -----------------------------------------------------------------------------
// mult_shift_add_core
// Radix-2 shift-add multiplier engine with optional two's-complement mode.
// Operands are snapshotted in LOAD, WIDTH CALC cycles follow, and FIX applies
// the sign and pulses done_pulse while product is valid.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request; accepted only in IDLE
//   a, b              operands (WIDTH bits)
//   signed_mode       1 = treat a/b as two's complement
//   busy              high in LOAD, CALC and FIX
//   done_pulse        one-cycle strobe in FIX; product valid in that cycle
//   product           2*WIDTH-bit result
// -----------------------------------------------------------------------------
module mult_shift_add_core
    import peripheral_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done_pulse,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // acc holds {partial product upper half, remaining multiplier bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_q, sign_d;
    logic [WIDTH:0]     sum;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
        end
    end

    // Extra bit keeps the carry out of the upper-half add before the shift
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        busy       = (state_q != ST_IDLE);
        done_pulse = 1'b0;
        product    = sign_q ? (~acc_q + 1'b1) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Magnitudes are unsigned, so |-2^(WIDTH-1)| still fits in WIDTH bits
                mcand_d = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
                acc_d   = {{WIDTH{1'b0}},
                           ((signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b)};
                sign_d  = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                cnt_d   = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                done_pulse = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/peripheral_mult_gen.sv
// -----------------------------------------------------------------------------
// peripheral_mult_gen
// Bus-mapped multiplier peripheral: register decode, CTRL/STATUS/RESULT
// registers and the level interrupt around mult_shift_add_core.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   d_in       write data (WIDTH)
//   cs         chip select qualifying rd/wr
//   addr       register byte offset (ADDR_W)
//   rd, wr     strobes; rd together with wr is treated as a write only
//   d_out      registered read data (2*WIDTH), holds between reads
//   irq        level interrupt = DONE & IE
// -----------------------------------------------------------------------------
module peripheral_mult_gen
    import peripheral_mult_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               cs,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               rd,
    input  logic               wr,
    output logic [2*WIDTH-1:0] d_out,
    output logic               irq
);

    localparam logic [ADDR_W-1:0] ADDR_A      = ADDR_W'(OFF_A);
    localparam logic [ADDR_W-1:0] ADDR_B      = ADDR_W'(OFF_B);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(OFF_CTRL);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(OFF_STATUS);
    localparam logic [ADDR_W-1:0] ADDR_RESULT = ADDR_W'(OFF_RESULT);

    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               signed_q, signed_d, ie_q, ie_d, done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d, d_out_q, d_out_d, rdata;

    logic               wr_en, rd_en, start_acc;
    logic               core_busy, core_done;
    logic [2*WIDTH-1:0] core_product;

    assign wr_en     = cs && wr;
    assign rd_en     = cs && rd && !wr;
    assign start_acc = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START_BIT] && !core_busy;

    mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (start_acc),
        .a           (a_q),
        .b           (b_q),
        .signed_mode (signed_q),
        .busy        (core_busy),
        .done_pulse  (core_done),
        .product     (core_product)
    );

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_A:      rdata = {{WIDTH{1'b0}}, a_q};
            ADDR_B:      rdata = {{WIDTH{1'b0}}, b_q};
            ADDR_CTRL: begin
                rdata[CTRL_SIGNED_BIT] = signed_q;
                rdata[CTRL_IE_BIT]     = ie_q;
            end
            ADDR_STATUS: begin
                rdata[STATUS_DONE_BIT] = done_q;
                rdata[STATUS_BUSY_BIT] = core_busy;
            end
            ADDR_RESULT: rdata = result_q;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        ie_d     = ie_q;
        done_d   = done_q;
        result_d = result_q;
        d_out_d  = rd_en ? rdata : d_out_q;

        if (wr_en) begin
            case (addr)
                ADDR_A:    a_d = d_in;
                ADDR_B:    b_d = d_in;
                ADDR_CTRL: begin
                    signed_d = d_in[CTRL_SIGNED_BIT];
                    ie_d     = d_in[CTRL_IE_BIT];
                end
                default: ;
            endcase
        end

        if (start_acc) done_d = 1'b0;
        if (rd_en && (addr == ADDR_STATUS)) done_d = 1'b0;
        // Completion is applied last so it wins over a same-edge read-clear
        if (core_done) begin
            done_d   = 1'b1;
            result_d = core_product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            d_out_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            result_q <= result_d;
            d_out_q  <= d_out_d;
        end
    end

    assign d_out = d_out_q;
    assign irq   = done_q && ie_q;

endmodule

// File: tb/tb_peripheral_mult_gen.sv
// -----------------------------------------------------------------------------
// tb_peripheral_mult_gen
// Directed bench for peripheral_mult_gen: a WIDTH=16 instance for the main
// sequence and a WIDTH=8 instance for the narrow-width case. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_peripheral_mult_gen;

    localparam logic [4:0] A_OFF   = 5'h04;
    localparam logic [4:0] B_OFF   = 5'h08;
    localparam logic [4:0] CTRL    = 5'h0C;
    localparam logic [4:0] STATUS  = 5'h10;
    localparam logic [4:0] RESULT  = 5'h14;
    localparam logic [4:0] UNMAP   = 5'h18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs16 = 1'b0, cs8 = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [15:0] d_in = '0;
    logic [31:0] d_out16;
    logic [15:0] d_out8;
    logic        irq16, irq8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    peripheral_mult_gen #(.WIDTH(16), .ADDR_W(5)) dut16 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs16), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out16), .irq(irq16)
    );

    peripheral_mult_gen #(.WIDTH(8), .ADDR_W(5)) dut8 (
        .clk(clk), .rst(rst), .d_in(d_in[7:0]), .cs(cs8), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out8), .irq(irq8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // sel=0 addresses the 16-bit instance, sel=1 the 8-bit one
    task automatic bus_write(input bit sel, input logic [4:0] a, input logic [15:0] data);
        @(negedge clk);
        cs16 = !sel; cs8 = sel; wr = 1'b1; addr = a; d_in = data;
        @(posedge clk);
        #1;
        cs16 = 1'b0; cs8 = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input bit sel, input logic [4:0] a, output logic [31:0] data);
        @(negedge clk);
        cs16 = !sel; cs8 = sel; rd = 1'b1; addr = a;
        @(posedge clk);
        #1;
        cs16 = 1'b0; cs8 = 1'b0; rd = 1'b0;
        data = sel ? {16'h0, d_out8} : d_out16;
    endtask

    task automatic read_check(input bit sel, input logic [4:0] a, input string tag,
                              input logic [31:0] exp);
        logic [31:0] v;
        bus_read(sel, a, v);
        check(tag, v, exp);
    endtask

    // Poll STATUS until DONE with a bounded number of reads
    task automatic wait_done(input bit sel, input string tag);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 60; i++) begin
            bus_read(sel, STATUS, s);
            if (s[0]) break;
        end
        check(tag, {31'h0, s[0]}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("reset d_out", d_out16, 32'h0);
        check("reset irq", {31'h0, irq16}, 32'h0);
        rst = 1'b0;
        read_check(0, STATUS, "reset status", 32'h0);
        read_check(0, RESULT, "reset result", 32'h0);
        read_check(0, A_OFF,  "reset A", 32'h0);

        // Unsigned 5 x 15 with exact latency observed on irq
        bus_write(0, A_OFF, 16'h0005);
        bus_write(0, B_OFF, 16'h000F);
        read_check(0, A_OFF, "A readback", 32'h5);
        bus_write(0, CTRL, 16'h0005);            // IE=1, START
        repeat (17) begin @(posedge clk); #1; end
        check("irq low at E17", {31'h0, irq16}, 32'h0);
        @(posedge clk); #1;
        check("irq high at E18", {31'h0, irq16}, 32'h1);
        read_check(0, STATUS, "status done", 32'h1);
        check("irq cleared by read", {31'h0, irq16}, 32'h0);
        read_check(0, STATUS, "status cleared", 32'h0);
        read_check(0, RESULT, "5x15", 32'h0000_004B);

        // Signed -3 x 7; CTRL write without START must not start
        bus_write(0, CTRL, 16'h0002);
        read_check(0, CTRL, "ctrl readback", 32'h2);
        read_check(0, STATUS, "no start on bit0=0", 32'h0);
        bus_write(0, A_OFF, 16'hFFFD);
        bus_write(0, B_OFF, 16'h0007);
        bus_write(0, CTRL, 16'h0003);
        wait_done(0, "done -3x7");
        read_check(0, RESULT, "-3x7", 32'hFFFF_FFEB);

        // Signed min x min
        bus_write(0, A_OFF, 16'h8000);
        bus_write(0, B_OFF, 16'h8000);
        bus_write(0, CTRL, 16'h0003);
        wait_done(0, "done min*min");
        read_check(0, RESULT, "min*min", 32'h4000_0000);

        // Unsigned max x max
        bus_write(0, A_OFF, 16'hFFFF);
        bus_write(0, B_OFF, 16'hFFFF);
        bus_write(0, CTRL, 16'h0001);
        wait_done(0, "done max*max");
        read_check(0, RESULT, "max*max", 32'hFFFE_0001);

        // START while busy and mid-operation write of A
        bus_write(0, A_OFF, 16'h0003);
        bus_write(0, B_OFF, 16'h0004);
        bus_write(0, CTRL, 16'h0001);
        read_check(0, STATUS, "busy flag", 32'h2);
        bus_write(0, A_OFF, 16'h0009);
        bus_write(0, CTRL, 16'h0005);            // ignored START, IE still set
        read_check(0, CTRL, "ctrl while busy", 32'h4);
        wait_done(0, "done busy test");
        read_check(0, RESULT, "3x4 snapshot", 32'h0000_000C);
        check("irq after read", {31'h0, irq16}, 32'h0);
        repeat (25) @(posedge clk);
        read_check(0, STATUS, "done once", 32'h0);
        read_check(0, A_OFF, "A written while busy", 32'h9);

        // Reset in CALC cycle 8
        bus_write(0, A_OFF, 16'h0005);
        bus_write(0, B_OFF, 16'h0006);
        bus_write(0, CTRL, 16'h0005);            // E0
        read_check(0, A_OFF, "A during calc", 32'h5);   // captured at E1
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid reset d_out", d_out16, 32'h0);
        check("mid reset irq", {31'h0, irq16}, 32'h0);
        rst = 1'b0;
        read_check(0, STATUS, "idle after reset", 32'h0);
        read_check(0, CTRL, "ctrl after reset", 32'h0);
        repeat (25) @(posedge clk);
        read_check(0, STATUS, "no done after reset", 32'h0);
        read_check(0, RESULT, "result after reset", 32'h0);
        bus_write(0, A_OFF, 16'h0005);
        bus_write(0, B_OFF, 16'h0006);
        bus_write(0, CTRL, 16'h0001);
        wait_done(0, "done after reset");
        read_check(0, RESULT, "5x6", 32'h0000_001E);

        // Unmapped offsets
        read_check(0, UNMAP, "unmapped 0x18", 32'h0);
        bus_write(0, UNMAP, 16'hFFFF);
        read_check(0, 5'h00, "unmapped 0x00", 32'h0);
        read_check(0, A_OFF, "A after unmapped wr", 32'h5);

        // WIDTH=8 instance: 0xFF x 0x02, DONE after 10 cycles
        bus_write(1, A_OFF, 16'h00FF);
        bus_write(1, B_OFF, 16'h0002);
        bus_write(1, CTRL, 16'h0005);
        repeat (9) begin @(posedge clk); #1; end
        check("w8 irq low at E9", {31'h0, irq8}, 32'h0);
        @(posedge clk); #1;
        check("w8 irq high at E10", {31'h0, irq8}, 32'h1);
        read_check(1, RESULT, "w8 0xFFx0x02", 32'h0000_01FE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
